brick_field_engine: RTL and testbench
=====================================

// Module: brick_field_engine
// PURPOSE
//  Parametrised brick-array manager for the breakout game. Stores NUM_BLOCKS bricks
//  (position + hit count), loaded serially at start of level. Once per frame it tests
//  the ball against every live brick, applies multi-hit damage and repaints every brick
//  through the VGA pixel port. Sits between the game FSM (ball/paddle) and vga_adapter.
// PARAMETERS
//  NUM_BLOCKS  8  number of bricks (1..32)
//  BLK_W       8  brick width in pixels (power of 2)
//  BLK_H       2  brick height in pixels (power of 2)
//  HIT_W       2  width of per-brick hit counter; 0 = destroyed
// PORTS
//  clock        in   1      system clock (CLOCK_50)
//  reset        in   1      asynchronous, active-high reset
//  restart      in   1      sync pulse: clear field, return to LOAD
//  load_valid   in   1      layout entry valid
//  load_ready   out  1      engine accepts layout entry
//  load_x       in   8      brick left x
//  load_y       in   8      brick top y
//  load_hits    in   HIT_W  initial hits (0 = empty slot)
//  frame_start  in   1      1-cycle frame tick (clock module output)
//  ball_x       in   8      ball x, sampled on accepted frame_start
//  ball_y       in   8      ball y, sampled on accepted frame_start
//  busy         out  1      scan/draw in progress
//  done         out  1      1-cycle pulse when frame pass completes
//  bounce       out  1      1-cycle pulse with done: ball hit a brick this frame
//  remaining    out  6      count of bricks with hits != 0
//  all_cleared  out  1      remaining == 0 and state != LOAD
//  vga_x        out  8      pixel x
//  vga_y        out  8      pixel y
//  vga_colour   out  3      pixel colour
//  vga_plot     out  1      pixel write strobe
// BEHAVIOUR
//  Reset: state=LOAD, all hits=0, load_ready=1, busy=0, done=0, bounce=0, remaining=0,
//   all_cleared=0, vga_x/y/colour=0, vga_plot=0. Reset or restart mid-pass aborts it.
//  States: LOAD -> IDLE -> SCAN -> DRAW -> FIN -> IDLE.
//  LOAD: entry accepted when load_valid&&load_ready; slot index 0..NUM_BLOCKS-1 in
//   order. Accepted entry with hits!=0 increments remaining. After last slot accepted,
//   load_ready drops next cycle, go IDLE.
//  IDLE: frame_start latches ball_x/ball_y, busy=1 next cycle, go SCAN. frame_start in
//   any other state is ignored (no queueing).
//  SCAN: one brick per cycle, index 0..NUM_BLOCKS-1. Hit when hits!=0 and
//   bx <= ball_x <= bx+BLK_W-1 and by <= ball_y <= by+BLK_H-1; sums computed 9 bits
//   wide (no 8-bit wrap). Only the lowest-index hit brick is damaged per frame:
//   hits -= 1; if it reaches 0, remaining -= 1. Later hits in the same scan ignored.
//  DRAW: for each brick in index order, BLK_W*BLK_H cycles, x-fastest raster:
//   vga_x=bx+col, vga_y=by+row, vga_plot=1. Colour from post-damage hits:
//   0->000 (erase), 1->010, 2->110, >=3->100. Coordinates >159 x / >119 y still emitted
//   (adapter clips). Outputs registered: pixel k appears one cycle after its counter.
//  FIN: done=1 for one cycle; bounce=1 same cycle iff a brick was damaged; busy=0; go IDLE.
//  Pass latency from frame_start: 1 + NUM_BLOCKS + NUM_BLOCKS*BLK_W*BLK_H + 1 cycles to
//   done (default 1+8+128+1 = 138).
//  vga_plot=0 outside DRAW; vga_x/y/colour hold last value.
// TESTING
//  Load 8 bricks y=30, x=15+16*i, hits=1; ball (20,31) frame_start -> bounce=1 at done,
//   brick0 drawn 16 pixels colour 000, remaining 8->7, done 138 cycles after tick.
//  Ball (16,30) overlapping bricks 0 and 1 (bx=15,16) -> only brick0 damaged, one bounce.
//  Brick hits=3: three hit frames -> colours 010... sequence 110,010,000; remaining drops once.
//  Brick bx=252, ball_x=3 -> no hit (no wrap); frame_start during DRAW -> ignored, single done.
//  Clear last brick -> all_cleared=1; restart -> load_ready=1, remaining=0, all_cleared=0.
//  Assert reset mid-DRAW -> vga_plot=0, busy=0, state LOAD immediately (async).

Source files
------------

// File: rtl/brick_field_engine.sv
`timescale 1ns/1ps
// brick_field_engine
// Holds NUM_BLOCKS bricks (position + remaining hits). The bricks are loaded serially at the
// start of a level. On each accepted frame tick the engine scans every brick against the
// latched ball position and damages the lowest-index brick that was hit. It then repaints
// every brick through the pixel port and pulses done, and bounce when a brick was damaged.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   restart             sync pulse: clear the field and return to loading
//   load_valid/ready    layout handshake; load_x/load_y/load_hits describe one slot
//   frame_start         1-cycle frame tick; ball_x/ball_y are latched when it is accepted
//   busy, done, bounce  pass status; done/bounce are 1-cycle pulses
//   remaining           number of bricks with hits != 0
//   all_cleared         remaining == 0 outside of loading
//   vga_x/y/colour/plot registered pixel stream
module brick_field_engine #(
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned BLK_W      = 8,
    parameter int unsigned BLK_H      = 2,
    parameter int unsigned HIT_W      = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             restart,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [7:0]       load_x,
    input  logic [7:0]       load_y,
    input  logic [HIT_W-1:0] load_hits,
    input  logic             frame_start,
    input  logic [7:0]       ball_x,
    input  logic [7:0]       ball_y,
    output logic             busy,
    output logic             done,
    output logic             bounce,
    output logic [5:0]       remaining,
    output logic             all_cleared,
    output logic [7:0]       vga_x,
    output logic [7:0]       vga_y,
    output logic [2:0]       vga_colour,
    output logic             vga_plot
);

    localparam int unsigned IDXW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int unsigned NPIX = BLK_W * BLK_H;
    localparam int unsigned PXW  = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BLOCKS - 1);
    localparam logic [PXW-1:0]  LAST_PX  = PXW'(NPIX - 1);

    localparam logic [2:0] StLoad = 3'd0;
    localparam logic [2:0] StIdle = 3'd1;
    localparam logic [2:0] StScan = 3'd2;
    localparam logic [2:0] StDraw = 3'd3;
    localparam logic [2:0] StFin  = 3'd4;

    logic [2:0]       state;
    logic [IDXW-1:0]  idx;       // load slot, scan brick and draw brick index
    logic [PXW-1:0]   px_cnt;    // raster position inside the current brick
    logic [7:0]       ball_xl;
    logic [7:0]       ball_yl;
    logic             damaged;   // a brick was already damaged in this pass
    logic [7:0]       blk_x    [NUM_BLOCKS];
    logic [7:0]       blk_y    [NUM_BLOCKS];
    logic [HIT_W-1:0] blk_hits [NUM_BLOCKS];
    logic             scan_hit;

    function automatic logic [2:0] hit_colour(input logic [HIT_W-1:0] h);
        int unsigned hv;
        hv = 32'(h);
        if (hv == 0)      return 3'b000;
        else if (hv == 1) return 3'b010;
        else if (hv == 2) return 3'b110;
        else              return 3'b100;
    endfunction

    // Bounds are compared 9 bits wide so a brick near x/y=255 never wraps onto low coordinates.
    always_comb begin
        scan_hit = 1'b0;
        if ((blk_hits[idx] != '0) &&
            ({1'b0, ball_xl} >= {1'b0, blk_x[idx]}) &&
            ({1'b0, ball_xl} <= {1'b0, blk_x[idx]} + 9'(BLK_W - 1)) &&
            ({1'b0, ball_yl} >= {1'b0, blk_y[idx]}) &&
            ({1'b0, ball_yl} <= {1'b0, blk_y[idx]} + 9'(BLK_H - 1))) begin
            scan_hit = 1'b1;
        end
    end

    assign load_ready  = (state == StLoad);
    assign all_cleared = (remaining == 6'd0) && (state != StLoad);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= StLoad;
            idx        <= '0;
            px_cnt     <= '0;
            ball_xl    <= '0;
            ball_yl    <= '0;
            damaged    <= 1'b0;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bounce     <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                blk_x[i]    <= '0;
                blk_y[i]    <= '0;
                blk_hits[i] <= '0;
            end
        end else if (restart) begin
            state     <= StLoad;
            idx       <= '0;
            px_cnt    <= '0;
            damaged   <= 1'b0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bounce    <= 1'b0;
            vga_plot  <= 1'b0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                blk_hits[i] <= '0;
            end
        end else begin
            done     <= 1'b0;
            bounce   <= 1'b0;
            vga_plot <= 1'b0;
            case (state)
                StLoad: begin
                    if (load_valid) begin
                        blk_x[idx]    <= load_x;
                        blk_y[idx]    <= load_y;
                        blk_hits[idx] <= load_hits;
                        if (load_hits != '0) remaining <= remaining + 6'd1;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= StIdle;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                StIdle: begin
                    if (frame_start) begin
                        ball_xl <= ball_x;
                        ball_yl <= ball_y;
                        busy    <= 1'b1;
                        damaged <= 1'b0;
                        idx     <= '0;
                        state   <= StScan;
                    end
                end
                StScan: begin
                    // Only the first (lowest-index) hit in a pass does damage.
                    if (scan_hit && !damaged) begin
                        blk_hits[idx] <= blk_hits[idx] - 1'b1;
                        damaged       <= 1'b1;
                        if (blk_hits[idx] == HIT_W'(1)) remaining <= remaining - 6'd1;
                    end
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        px_cnt <= '0;
                        state  <= StDraw;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                StDraw: begin
                    vga_plot   <= 1'b1;
                    vga_x      <= blk_x[idx] + 8'(32'(px_cnt) % BLK_W);
                    vga_y      <= blk_y[idx] + 8'(32'(px_cnt) / BLK_W);
                    vga_colour <= hit_colour(blk_hits[idx]);
                    if (px_cnt == LAST_PX) begin
                        px_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= StFin;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        px_cnt <= px_cnt + 1'b1;
                    end
                end
                StFin: begin
                    done   <= 1'b1;
                    bounce <= damaged;
                    busy   <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_brick_field_engine.sv
`timescale 1ns/1ps
module tb_brick_field_engine;

    localparam int NB  = 8;
    localparam int BW  = 8;
    localparam int BH  = 2;
    localparam int HW  = 2;
    localparam int LAT = 1 + NB + NB * BW * BH + 1;

    logic          clock;
    logic          reset;
    logic          restart;
    logic          load_valid;
    logic          load_ready;
    logic [7:0]    load_x;
    logic [7:0]    load_y;
    logic [HW-1:0] load_hits;
    logic          frame_start;
    logic [7:0]    ball_x;
    logic [7:0]    ball_y;
    logic          busy;
    logic          done;
    logic          bounce;
    logic [5:0]    remaining;
    logic          all_cleared;
    logic [7:0]    vga_x;
    logic [7:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;

    int tests = 0;
    int fails = 0;

    // Reference model of the field
    int m_x[NB];
    int m_y[NB];
    int m_h[NB];
    int m_rem;
    logic [18:0] got_q[$];
    logic [18:0] exp_q[$];

    brick_field_engine #(
        .NUM_BLOCKS(NB),
        .BLK_W     (BW),
        .BLK_H     (BH),
        .HIT_W     (HW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .restart    (restart),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_x     (load_x),
        .load_y     (load_y),
        .load_hits  (load_hits),
        .frame_start(frame_start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .busy       (busy),
        .done       (done),
        .bounce     (bounce),
        .remaining  (remaining),
        .all_cleared(all_cleared),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] colour_of(input int h);
        if (h == 0)      return 3'b000;
        else if (h == 1) return 3'b010;
        else if (h == 2) return 3'b110;
        else             return 3'b100;
    endfunction

    task automatic do_restart();
        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        for (int i = 0; i < NB; i++) m_h[i] = 0;
        m_rem = 0;
        check("restart_load_ready", load_ready, 1);
        check("restart_remaining", remaining, 0);
        check("restart_all_cleared", all_cleared, 0);
    endtask

    task automatic load_from_model();
        m_rem = 0;
        for (int i = 0; i < NB; i++) begin
            @(negedge clock);
            load_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clock);
            load_valid = 1'b1;
            load_x     = 8'(m_x[i]);
            load_y     = 8'(m_y[i]);
            load_hits  = HW'(m_h[i]);
            if (i == 0) check("load_ready_high", load_ready, 1);
            @(posedge clock);
            if (m_h[i] != 0) m_rem++;
        end
        @(negedge clock);
        load_valid = 1'b0;
        check("load_ready_drop", load_ready, 0);
        check("remaining_after_load", remaining, m_rem);
        check("not_cleared_after_load", all_cleared, (m_rem == 0));
    endtask

    // One frame: model computes damage and the expected pixel stream, then the DUT is run.
    // poke > 0 pulses frame_start again that many cycles into the pass.
    task automatic run_frame(input int bxl, input int byl, input int poke);
        int hit;
        int cnt;
        int got;
        int nbad;
        int extra;
        hit = -1;
        for (int i = 0; i < NB; i++) begin
            if (hit < 0 && m_h[i] != 0 && bxl >= m_x[i] && bxl <= m_x[i] + BW - 1 &&
                byl >= m_y[i] && byl <= m_y[i] + BH - 1) hit = i;
        end
        if (hit >= 0) begin
            m_h[hit]--;
            if (m_h[hit] == 0) m_rem--;
        end
        exp_q.delete();
        for (int i = 0; i < NB; i++)
            for (int r = 0; r < BH; r++)
                for (int c = 0; c < BW; c++)
                    exp_q.push_back({8'((m_x[i] + c) & 255), 8'((m_y[i] + r) & 255),
                                     colour_of(m_h[i])});
        got_q.delete();
        @(negedge clock);
        frame_start = 1'b1;
        ball_x      = 8'(bxl);
        ball_y      = 8'(byl);
        cnt = 0;
        got = 0;
        while (got == 0 && cnt < LAT + 40) begin
            @(posedge clock);
            cnt++;
            @(negedge clock);
            frame_start = (cnt == poke);
            ball_x      = 8'($urandom);
            ball_y      = 8'($urandom);
            if (cnt == 1) check("busy_rise", busy, 1);
            if (vga_plot === 1'b1) got_q.push_back({vga_x, vga_y, vga_colour});
            if (done === 1'b1) got = cnt;
        end
        frame_start = 1'b0;
        check("done_latency", got, LAT);
        check("bounce", bounce, (hit >= 0));
        check("busy_fall", busy, 0);
        check("remaining", remaining, m_rem);
        check("all_cleared", all_cleared, (m_rem == 0));
        check("pix_count", got_q.size(), exp_q.size());
        nbad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) nbad++;
        check("pix_data", nbad, 0);
        if (poke > 0) begin
            extra = 0;
            repeat (LAT + 20) begin
                @(negedge clock);
                if (done === 1'b1) extra++;
            end
            check("no_queued_done", extra, 0);
        end
    endtask

    initial begin
        logic [18:0] p;
        int k;
        int bxl;
        int byl;
        clock       = 1'b0;
        reset       = 1'b1;
        restart     = 1'b0;
        load_valid  = 1'b0;
        load_x      = '0;
        load_y      = '0;
        load_hits   = '0;
        frame_start = 1'b0;
        ball_x      = '0;
        ball_y      = '0;
        m_rem       = 0;

        @(negedge clock);
        check("rst_load_ready", load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bounce", bounce, 0);
        check("rst_remaining", remaining, 0);
        check("rst_all_cleared", all_cleared, 0);
        check("rst_vga_xyc", {vga_x, vga_y, vga_colour}, 0);
        check("rst_vga_plot", vga_plot, 0);
        @(negedge clock);
        reset = 1'b0;

        // Row of single-hit bricks; ball inside brick 0
        for (int i = 0; i < NB; i++) begin
            m_x[i] = 15 + 16 * i;
            m_y[i] = 30;
            m_h[i] = 1;
        end
        load_from_model();
        run_frame(20, 31, 0);
        p = (got_q.size() > 0) ? got_q[0] : 'x;
        check("row_b0_erased", p[2:0], 3'b000);
        check("row_remaining7", remaining, 7);

        // Overlapping bricks, multi-hit brick, no-wrap brick, ignored tick during DRAW
        do_restart();
        m_x[0] = 15;  m_y[0] = 30; m_h[0] = 3;
        m_x[1] = 16;  m_y[1] = 30; m_h[1] = 1;
        m_x[2] = 252; m_y[2] = 50; m_h[2] = 1;
        for (int i = 3; i < NB; i++) begin
            m_x[i] = 20 * i;
            m_y[i] = 100;
            m_h[i] = 2;
        end
        load_from_model();
        run_frame(16, 30, 0);
        p = (got_q.size() > 0) ? got_q[0] : 'x;
        check("multi_colour_hit1", p[2:0], 3'b110);
        run_frame(16, 30, 0);
        p = (got_q.size() > 0) ? got_q[0] : 'x;
        check("multi_colour_hit2", p[2:0], 3'b010);
        check("multi_rem_held", remaining, 8);
        run_frame(16, 30, 0);
        p = (got_q.size() > 0) ? got_q[0] : 'x;
        check("multi_colour_hit3", p[2:0], 3'b000);
        check("multi_rem_drop", remaining, 7);
        run_frame(16, 30, 0);
        run_frame(3, 50, 50);

        // Random layouts and ball positions near random bricks
        do_restart();
        for (int i = 0; i < NB; i++) begin
            m_x[i] = $urandom_range(0, 255);
            m_y[i] = $urandom_range(0, 255);
            m_h[i] = $urandom_range(0, 3);
        end
        load_from_model();
        repeat (8) begin
            k   = $urandom_range(0, NB - 1);
            bxl = (m_x[k] + int'($urandom_range(0, 11)) - 2) & 255;
            byl = (m_y[k] + int'($urandom_range(0, 5)) - 2) & 255;
            run_frame(bxl, byl, 0);
        end

        // Clear the field, then restart
        do_restart();
        for (int i = 0; i < NB; i++) begin
            m_x[i] = 10 * i;
            m_y[i] = 200;
            m_h[i] = 0;
        end
        m_x[5] = 100; m_y[5] = 60; m_h[5] = 1;
        m_x[6] = 0;   m_y[6] = 0;  m_h[6] = 1;
        load_from_model();
        run_frame(103, 61, 0);
        run_frame(7, 1, 0);
        check("cleared_flag", all_cleared, 1);
        do_restart();

        // Asynchronous reset in the middle of the draw phase
        for (int i = 0; i < NB; i++) begin
            m_x[i] = $urandom_range(0, 150);
            m_y[i] = $urandom_range(0, 110);
            m_h[i] = $urandom_range(1, 3);
        end
        load_from_model();
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        repeat (40) @(negedge clock);
        check("plot_before_reset", vga_plot, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_plot", vga_plot, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_load_ready", load_ready, 1);
        check("async_rst_remaining", remaining, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_load_ready", load_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
